// File: rtl/game_pkg.sv
// game_pkg: shared state encoding, slot defaults and popcount helper for the game object controller
package game_pkg;
    localparam int STATE_W     = 2;
    localparam int N_BULLET_DEF = 5;
    localparam int N_ENEMY_DEF  = 6;
    localparam int MAX_SLOTS    = 16;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_DYING = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    function automatic logic [4:0] popcount(input logic [MAX_SLOTS-1:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < MAX_SLOTS; i++) c = c + 5'(v[i]);
        return c;
    endfunction
endpackage

// File: rtl/game_obj_ctrl_slot_pool.sv
// slot_pool: slot bitmap with lowest-free allocation and registered grant
//  clk, reset   clock, synchronous active-high reset
//  req          allocation request (one-cycle pulse)
//  en           allocation allowed; when low the bitmap is forced to 0
//  free         per-slot retire; clears matching active bits
//  active       registered slot bitmap
//  grant, idx   registered grant pulse and granted slot
//  refused      combinational: req that cannot be granted this cycle
module slot_pool #(
    parameter int N = 5,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          en,
    input  logic [N-1:0]  free,
    output logic [N-1:0]  active,
    output logic          grant,
    output logic [IW-1:0] idx,
    output logic          refused
);
    logic [IW-1:0] free_idx;
    logic          found;
    logic          take;

    // Scan from the top so the lowest clear bit is the last one written.
    always_comb begin
        free_idx = '0;
        found    = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!active[i]) begin
                free_idx = IW'(i);
                found    = 1'b1;
            end
        end
    end

    assign take    = req && en && found;
    assign refused = req && !take;

    // Allocation looks only at the registered bitmap, so a slot freed this
    // cycle cannot be handed out again until the next one.
    always_ff @(posedge clk) begin
        if (reset) begin
            active <= '0;
            grant  <= 1'b0;
            idx    <= '0;
        end else begin
            active <= en ? ((active & ~free) | (take ? (N'(1) << free_idx) : '0)) : '0;
            grant  <= take;
            if (take) idx <= free_idx;
        end
    end
endmodule

// File: rtl/game_obj_ctrl.sv
// game_obj_ctrl: run/dead FSM, bullet and enemy slot allocation, saturating kill score
//  clk, reset                     clock, synchronous active-high reset
//  tick                           frame strobe, paces the DYING countdown
//  start                          start/restart level, rising edge detected here
//  fire, spawn                    bullet / enemy allocation requests
//  bullet_free, enemy_kill        per-slot retire bits
//  player_hit                     player collision, ends the run
//  state, dead                    FSM state and dead flag
//  bullet_active, enemy_active    slot bitmaps
//  fire_grant/fire_idx, spawn_grant/spawn_idx   registered allocation results
//  alloc_drop                     a fire or spawn request was refused
//  score                          saturating kill count
module game_obj_ctrl
    import game_pkg::*;
#(
    parameter int N_BULLET   = N_BULLET_DEF,
    parameter int N_ENEMY    = N_ENEMY_DEF,
    parameter int DEAD_TICKS = 60,
    parameter int SCORE_W    = 10,
    localparam int BW = (N_BULLET > 1) ? $clog2(N_BULLET) : 1,
    localparam int EW = (N_ENEMY > 1) ? $clog2(N_ENEMY) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic                start,
    input  logic                fire,
    input  logic                spawn,
    input  logic [N_BULLET-1:0] bullet_free,
    input  logic [N_ENEMY-1:0]  enemy_kill,
    input  logic                player_hit,
    output logic [STATE_W-1:0]  state,
    output logic                dead,
    output logic [N_BULLET-1:0] bullet_active,
    output logic [N_ENEMY-1:0]  enemy_active,
    output logic                fire_grant,
    output logic [BW-1:0]       fire_idx,
    output logic                spawn_grant,
    output logic [EW-1:0]       spawn_idx,
    output logic                alloc_drop,
    output logic [SCORE_W-1:0]  score
);
    localparam int CW = $clog2(DEAD_TICKS + 1);
    localparam int SW = SCORE_W + 5;

    state_t        st;
    logic [CW-1:0] cnt;
    logic          start_q;
    logic          start_rise;
    logic          en;
    logic          b_ref;
    logic          e_ref;
    logic [4:0]    kills;
    logic [SW-1:0] sum;
    logic [SCORE_W-1:0] score_next;

    assign start_rise = start && !start_q;
    // A hit wins over allocation, and dropping en also wipes both bitmaps
    // on the edge that enters DYING and keeps them empty outside PLAY.
    assign en         = (st == ST_PLAY) && !player_hit;
    assign kills      = popcount(MAX_SLOTS'(enemy_kill & enemy_active));
    assign sum        = SW'(score) + SW'(kills);
    assign score_next = (sum > SW'({SCORE_W{1'b1}})) ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
    assign state      = st;

    slot_pool #(.N(N_BULLET)) u_bullets (
        .clk     (clk),
        .reset   (reset),
        .req     (fire),
        .en      (en),
        .free    (bullet_free),
        .active  (bullet_active),
        .grant   (fire_grant),
        .idx     (fire_idx),
        .refused (b_ref)
    );

    slot_pool #(.N(N_ENEMY)) u_enemies (
        .clk     (clk),
        .reset   (reset),
        .req     (spawn),
        .en      (en),
        .free    (enemy_kill),
        .active  (enemy_active),
        .grant   (spawn_grant),
        .idx     (spawn_idx),
        .refused (e_ref)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            st         <= ST_IDLE;
            dead       <= 1'b0;
            cnt        <= '0;
            score      <= '0;
            start_q    <= 1'b0;
            alloc_drop <= 1'b0;
        end else begin
            start_q    <= start;
            alloc_drop <= b_ref || e_ref;
            case (st)
                ST_IDLE: if (start_rise) begin
                    st    <= ST_PLAY;
                    score <= '0;
                end
                ST_PLAY: begin
                    score <= score_next;
                    if (player_hit) begin
                        st   <= ST_DYING;
                        dead <= 1'b1;
                        cnt  <= CW'(DEAD_TICKS);
                    end
                end
                ST_DYING: begin
                    if (cnt == '0) st <= ST_OVER;
                    else if (tick) cnt <= cnt - 1'b1;
                end
                ST_OVER: if (start_rise) begin
                    st   <= ST_IDLE;
                    dead <= 1'b0;
                end
                default: st <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_game_obj_ctrl.sv
// tb_game_obj_ctrl: directed self-checking bench for game_obj_ctrl with default parameters
module tb_game_obj_ctrl;
    logic       clk = 1'b0;
    logic       reset, tick, start, fire, spawn, player_hit;
    logic [4:0] bullet_free;
    logic [5:0] enemy_kill;
    logic [1:0] state;
    logic       dead, fire_grant, spawn_grant, alloc_drop;
    logic [4:0] bullet_active;
    logic [5:0] enemy_active;
    logic [2:0] fire_idx, spawn_idx;
    logic [9:0] score;
    int         n_cmp = 0;
    int         n_bad = 0;

    game_obj_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .tick          (tick),
        .start         (start),
        .fire          (fire),
        .spawn         (spawn),
        .bullet_free   (bullet_free),
        .enemy_kill    (enemy_kill),
        .player_hit    (player_hit),
        .state         (state),
        .dead          (dead),
        .bullet_active (bullet_active),
        .enemy_active  (enemy_active),
        .fire_grant    (fire_grant),
        .fire_idx      (fire_idx),
        .spawn_grant   (spawn_grant),
        .spawn_idx     (spawn_idx),
        .alloc_drop    (alloc_drop),
        .score         (score)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; start = 1'b0; fire = 1'b0; spawn = 1'b0;
        player_hit = 1'b0; bullet_free = '0; enemy_kill = '0;
        step(); step();
        reset = 1'b0;
        chk("rst_state", 32'(state), 0);
        chk("rst_dead", 32'(dead), 0);
        chk("rst_bullets", 32'(bullet_active), 0);
        chk("rst_enemies", 32'(enemy_active), 0);
        chk("rst_score", 32'(score), 0);
        chk("rst_grant", 32'(fire_grant), 0);
        chk("rst_drop", 32'(alloc_drop), 0);

        fire = 1'b1; step(); fire = 1'b0;
        chk("idle_fire_drop", 32'(alloc_drop), 1);
        chk("idle_fire_grant", 32'(fire_grant), 0);
        chk("idle_bullets", 32'(bullet_active), 0);

        start = 1'b1; step();
        chk("start_play", 32'(state), 1);
        step(); start = 1'b0;
        chk("start_held", 32'(state), 1);
        chk("play_score", 32'(score), 0);

        for (int i = 0; i < 5; i++) begin
            fire = 1'b1; step();
            chk("fire_grant", 32'(fire_grant), 1);
            chk("fire_idx", 32'(fire_idx), 32'(i));
        end
        step(); fire = 1'b0;
        chk("full_drop", 32'(alloc_drop), 1);
        chk("full_grant", 32'(fire_grant), 0);
        chk("full_bitmap", 32'(bullet_active), 32'h1f);

        fire = 1'b1; bullet_free = 5'b00100; step();
        chk("free_same_drop", 32'(alloc_drop), 1);
        chk("free_same_grant", 32'(fire_grant), 0);
        chk("free_same_bitmap", 32'(bullet_active), 32'h1b);
        bullet_free = '0; step(); fire = 1'b0;
        chk("refire_grant", 32'(fire_grant), 1);
        chk("refire_idx", 32'(fire_idx), 2);
        chk("refire_bitmap", 32'(bullet_active), 32'h1f);

        for (int i = 0; i < 3; i++) begin
            spawn = 1'b1; step();
            chk("spawn_idx", 32'(spawn_idx), 32'(i));
        end
        spawn = 1'b0;
        chk("enemy_bitmap", 32'(enemy_active), 32'h07);
        enemy_kill = 6'b001011; step(); enemy_kill = '0;
        chk("kill_score", 32'(score), 2);
        chk("kill_bitmap", 32'(enemy_active), 32'h04);

        fire = 1'b1; spawn = 1'b1; step(); fire = 1'b0; spawn = 1'b0;
        chk("mixed_spawn_grant", 32'(spawn_grant), 1);
        chk("mixed_spawn_idx", 32'(spawn_idx), 0);
        chk("mixed_fire_grant", 32'(fire_grant), 0);
        chk("mixed_drop", 32'(alloc_drop), 1);

        player_hit = 1'b1; spawn = 1'b1; step(); player_hit = 1'b0; spawn = 1'b0;
        chk("hit_no_grant", 32'(spawn_grant), 0);
        chk("hit_dead", 32'(dead), 1);
        chk("hit_state", 32'(state), 2);
        chk("hit_bullets", 32'(bullet_active), 0);
        chk("hit_enemies", 32'(enemy_active), 0);
        repeat (59) begin
            tick = 1'b1; step(); tick = 1'b0; step();
        end
        chk("dying_59", 32'(state), 2);
        tick = 1'b1; step(); tick = 1'b0;
        chk("dying_60", 32'(state), 2);
        step();
        chk("over_state", 32'(state), 3);
        chk("over_dead", 32'(dead), 1);
        fire = 1'b1; step(); fire = 1'b0;
        chk("over_drop", 32'(alloc_drop), 1);
        chk("over_bullets", 32'(bullet_active), 0);

        start = 1'b1; step(); start = 1'b0;
        chk("restart_idle", 32'(state), 0);
        chk("restart_dead", 32'(dead), 0);
        step();
        start = 1'b1; step(); start = 1'b0;
        chk("replay_state", 32'(state), 1);
        chk("replay_score", 32'(score), 0);
        fire = 1'b1; step();
        chk("replay_bitmap", 32'(bullet_active), 32'h01);
        reset = 1'b1; step(); reset = 1'b0; fire = 1'b0;
        chk("abort_state", 32'(state), 0);
        chk("abort_grant", 32'(fire_grant), 0);
        chk("abort_bitmap", 32'(bullet_active), 0);
        step();

        start = 1'b1; step(); start = 1'b0;
        chk("sat_play", 32'(state), 1);
        for (int r = 0; r < 172; r++) begin
            spawn = 1'b1; repeat (6) step(); spawn = 1'b0;
            enemy_kill = 6'h3f; step(); enemy_kill = '0;
            if (r == 169) chk("score_1020", 32'(score), 1020);
            if (r == 170) chk("score_sat", 32'(score), 1023);
        end
        chk("score_hold", 32'(score), 1023);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
